mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 clock  in  1  system clock; all state changes on rising edge.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 f_req  in  1  instruction-fetch read request, sampled only in IDLE.
REQ-004 f_addr  in  32  fetch byte address.
REQ-005 d_req  in  1  data-access request, sampled only in IDLE.
REQ-006 d_we  in  1  data access type: 1 = write, 0 = read.
REQ-007 d_addr  in  32  data byte address.
REQ-008 d_wdata  in  32  data write value.
REQ-009 f_gnt  out  1  high while the fetch requester owns the port (ACCESS..RESP).
REQ-010 d_gnt  out  1  high while the data requester owns the port (ACCESS..RESP).
REQ-011 f_done  out  1  one-cycle pulse in RESP when the owner is fetch.
REQ-012 d_done  out  1  one-cycle pulse in RESP when the owner is data.
REQ-013 rdata  out  32  registered read data; valid from the RESP cycle until the next capture.
REQ-014 mem_addr  out  32  memory address, held constant for ACCESS, WAIT1 and WAIT2.
REQ-015 mem_wdata  out  32  memory write data; latched d_wdata, or 0 for fetch.
REQ-016 mem_wr  out  1  memory write strobe: 1 = write, 0 = read.
REQ-017 mem_rdata  in  32  memory read data, valid in WAIT2.
REQ-018 state_out  out  3  current FSM state encoding for debug: IDLE=0, ACCESS=1, WAIT1=2, WAIT2=3, RESP=4.

Function
REQ-019 FSM states and transitions SHALL be:
- IDLE->ACCESS when any request is present, otherwise stay in IDLE.
- ACCESS->WAIT1->WAIT2->RESP->IDLE, unconditionally.
REQ-020 On IDLE->ACCESS the block SHALL latch owner, address, write flag and write data into internal registers; requester inputs are don't-care afterwards.
REQ-021 A fetch access SHALL always be a read with mem_wdata = 0.
REQ-022 mem_wr SHALL be 1 only in the ACCESS cycle of a data write.
REQ-023 rdata SHALL capture mem_rdata at the WAIT2->RESP edge on reads and SHALL be left unchanged on writes.
REQ-024 Latency SHALL be fixed:
- request seen in IDLE at cycle T -> gnt from T+1;
- done and rdata valid at T+4.
- gnt SHALL drop at T+5 (IDLE).
REQ-025 Fixed priority SHALL apply when both requests are present in the same IDLE cycle: data wins, and fetch is served in a later IDLE.
REQ-026 Requesters SHALL deassert req in the cycle after done. A req still high in IDLE SHALL start a new access, which gives a minimum request spacing of 5 cycles.
REQ-027 f_gnt and d_gnt SHALL never both be 1; f_done and d_done SHALL never both be 1.
REQ-028 Addresses SHALL pass through unmodified, with no alignment check and no wrap handling.

Reset
REQ-029 Reset SHALL immediately force IDLE; the internal last-owner register SHALL reset to fetch.
REQ-030 Every output SHALL reset to 0, including rdata, mem_addr and mem_wdata.
REQ-031 Reset asserted during an access SHALL drop mem_wr asynchronously and abandon the access; no done is issued.
REQ-032 After reset deasserts, the first rising edge SHALL evaluate IDLE normally.

Configuration
REQ-033 When MEM_PORT_ARB_RR_EN is defined, ties SHALL be resolved round-robin:
- the requester not served last wins;
- the last-owner register updates at every IDLE->ACCESS.
- The first tie after reset grants data.
REQ-034 When MEM_PORT_ARB_RR_EN is undefined, REQ-025 fixed data priority applies and the last-owner register is not implemented.

Verification
REQ-035 Fetch only: f_req=1, f_addr=0x0000_0040, mem_rdata=0x2000_0008 in WAIT2 -> f_gnt from T+1, f_done and rdata=0x2000_0008 at T+4.
REQ-036 Data write: d_req=1, d_we=1, d_addr=0x0000_0100, d_wdata=0xDEAD_BEEF -> mem_wr=1 only at T+1, mem_addr=0x100 for T+1..T+3, d_done at T+4, rdata unchanged.
REQ-037 Tie, fixed build: f_req and d_req held until their respective done -> data served first (d_done T+4), then fetch (f_done T+9).
REQ-038 Tie, MEM_PORT_ARB_RR_EN build, both requests held continuously with each requester re-asserting after its done -> grant order data, fetch, data, fetch.
REQ-039 Reset pulse during WAIT1 of a data write -> state_out=0, all outputs 0, no done; a later fetch completes normally with 4-cycle latency.
REQ-040 Requester changes d_addr from 0x10 to 0x20 at T+2 -> mem_addr stays 0x10 through WAIT2.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester (fetch/data) single-port memory arbiter with fixed 4-cycle access
// Tie resolution is fixed data priority; define MEM_PORT_ARB_RR_EN for round-robin ties.
module mem_port_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        f_gnt,
    output logic        d_gnt,
    output logic        f_done,
    output logic        d_done,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wr,
    input  logic [31:0] mem_rdata,
    output logic [2:0]  state_out
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ACCESS = 3'd1;
    localparam logic [2:0] WAIT1  = 3'd2;
    localparam logic [2:0] WAIT2  = 3'd3;
    localparam logic [2:0] RESP   = 3'd4;

    logic [2:0]  state;
    logic [2:0]  state_next;
    logic        owner;          // 1 = data, 0 = fetch; doubles as last-owner for round-robin
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        grant_data;
    logic        start;

    assign start = (state == IDLE) && (f_req || d_req);

    always_comb begin
        grant_data = d_req;
`ifdef MEM_PORT_ARB_RR_EN
        if (f_req && d_req) begin
            grant_data = ~owner;
        end
`endif
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? ACCESS : IDLE;
            ACCESS:  state_next = WAIT1;
            WAIT1:   state_next = WAIT2;
            WAIT2:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            owner   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state <= state_next;
            if (start) begin
                owner   <= grant_data;
                addr_q  <= grant_data ? d_addr : f_addr;
                we_q    <= grant_data & d_we;
                wdata_q <= grant_data ? d_wdata : 32'd0;
            end
            // Writes leave the previous read value visible.
            if (state == WAIT2 && !we_q) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    assign f_gnt     = (state != IDLE) && !owner;
    assign d_gnt     = (state != IDLE) && owner;
    assign f_done    = (state == RESP) && !owner;
    assign d_done    = (state == RESP) && owner;
    assign mem_wr    = (state == ACCESS) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;
    assign state_out = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - table-driven bench for mem_port_arbiter plus tie, round-robin and reset sequences
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        f_req, d_req, d_we;
    logic [31:0] f_addr, d_addr, d_wdata, mem_rdata;
    logic        f_gnt, d_gnt, f_done, d_done, mem_wr;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [2:0]  state_out;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter dut (
        .clock(clock), .reset(reset),
        .f_req(f_req), .f_addr(f_addr),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .f_gnt(f_gnt), .d_gnt(d_gnt), .f_done(f_done), .d_done(d_done),
        .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .state_out(state_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        f_req;
        logic [31:0] f_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [31:0] mem_rdata;
        logic [2:0]  e_state;
        logic [4:0]  e_flags;   // {f_gnt, d_gnt, f_done, d_done, mem_wr}
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic fr, logic [31:0] fa, logic dr, logic dw, logic [31:0] da,
                                logic [31:0] dwd, logic [31:0] mr, logic [2:0] st, logic [4:0] fl,
                                logic [31:0] ea, logic [31:0] ew, logic [31:0] er);
        vec_t v;
        v.f_req = fr; v.f_addr = fa; v.d_req = dr; v.d_we = dw; v.d_addr = da; v.d_wdata = dwd;
        v.mem_rdata = mr; v.e_state = st; v.e_flags = fl; v.e_addr = ea; v.e_wdata = ew; v.e_rdata = er;
        return v;
    endfunction

    function automatic logic [103:0] observed();
        return {state_out, f_gnt, d_gnt, f_done, d_done, mem_wr, mem_addr, mem_wdata, rdata};
    endfunction

    task automatic chk(input string name, input logic [103:0] act, input logic [103:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        f_req = 0; d_req = 0; d_we = 0;
        f_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        reset = 0;
    endtask

    initial begin
        int dd_cyc, fd_cyc, n, lat;
        logic got[4];
        int   exp_ord[4];

        idle_inputs();
        reset = 1;
        tick();
        tick();
        chk("reset_outputs", observed(), 104'd0);
        reset = 0;

        // fetch read, f_req held until after done, address changes after latch
        vecs.push_back(mk(1, 32'h40,       0, 0, 0, 0, 0,            3'd1, 5'b10000, 32'h40, 0, 0));
        vecs.push_back(mk(1, 32'hFFFFFFFC, 0, 0, 0, 0, 0,            3'd2, 5'b10000, 32'h40, 0, 0));
        vecs.push_back(mk(1, 32'hFFFFFFFC, 0, 0, 0, 0, 0,            3'd3, 5'b10000, 32'h40, 0, 0));
        vecs.push_back(mk(1, 32'hFFFFFFFC, 0, 0, 0, 0, 32'h20000008, 3'd4, 5'b10100, 32'h40, 0, 32'h20000008));
        vecs.push_back(mk(1, 32'hFFFFFFFC, 0, 0, 0, 0, 0,            3'd0, 5'b00000, 32'h40, 0, 32'h20000008));
        vecs.push_back(mk(0, 0,            0, 0, 0, 0, 0,            3'd0, 5'b00000, 32'h40, 0, 32'h20000008));
        // data write: mem_wr only in ACCESS, rdata untouched
        vecs.push_back(mk(0, 0, 1, 1, 32'h100, 32'hDEADBEEF, 0,            3'd1, 5'b01001, 32'h100, 32'hDEADBEEF, 32'h20000008));
        vecs.push_back(mk(0, 0, 1, 1, 32'h100, 32'hDEADBEEF, 0,            3'd2, 5'b01000, 32'h100, 32'hDEADBEEF, 32'h20000008));
        vecs.push_back(mk(0, 0, 1, 1, 32'h100, 32'hDEADBEEF, 0,            3'd3, 5'b01000, 32'h100, 32'hDEADBEEF, 32'h20000008));
        vecs.push_back(mk(0, 0, 1, 1, 32'h100, 32'hDEADBEEF, 32'h12345678, 3'd4, 5'b01010, 32'h100, 32'hDEADBEEF, 32'h20000008));
        vecs.push_back(mk(0, 0, 1, 1, 32'h100, 32'hDEADBEEF, 0,            3'd0, 5'b00000, 32'h100, 32'hDEADBEEF, 32'h20000008));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,                             3'd0, 5'b00000, 32'h100, 32'hDEADBEEF, 32'h20000008));
        // data read; d_addr changes from 0x10 to 0x20 mid-access
        vecs.push_back(mk(0, 0, 1, 0, 32'h10, 32'h77, 0,            3'd1, 5'b01000, 32'h10, 32'h77, 32'h20000008));
        vecs.push_back(mk(0, 0, 1, 0, 32'h10, 32'h77, 0,            3'd2, 5'b01000, 32'h10, 32'h77, 32'h20000008));
        vecs.push_back(mk(0, 0, 1, 0, 32'h20, 32'h77, 0,            3'd3, 5'b01000, 32'h10, 32'h77, 32'h20000008));
        vecs.push_back(mk(0, 0, 1, 0, 32'h20, 32'h77, 32'hCAFE0010, 3'd4, 5'b01010, 32'h10, 32'h77, 32'hCAFE0010));
        vecs.push_back(mk(0, 0, 1, 0, 32'h20, 32'h77, 0,            3'd0, 5'b00000, 32'h10, 32'h77, 32'hCAFE0010));
        // d_req still high in IDLE starts a new (write) access
        vecs.push_back(mk(0, 0, 1, 1, 32'h20, 32'h99, 0,            3'd1, 5'b01001, 32'h20, 32'h99, 32'hCAFE0010));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,                      3'd2, 5'b01000, 32'h20, 32'h99, 32'hCAFE0010));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,                      3'd3, 5'b01000, 32'h20, 32'h99, 32'hCAFE0010));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h5,                  3'd4, 5'b01010, 32'h20, 32'h99, 32'hCAFE0010));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,                      3'd0, 5'b00000, 32'h20, 32'h99, 32'hCAFE0010));
        // unaligned top-of-range fetch passes through untouched
        vecs.push_back(mk(1, 32'hFFFFFFFF, 0, 0, 0, 0, 0,            3'd1, 5'b10000, 32'hFFFFFFFF, 0, 32'hCAFE0010));
        vecs.push_back(mk(0, 0,            0, 0, 0, 0, 0,            3'd2, 5'b10000, 32'hFFFFFFFF, 0, 32'hCAFE0010));
        vecs.push_back(mk(0, 0,            0, 0, 0, 0, 0,            3'd3, 5'b10000, 32'hFFFFFFFF, 0, 32'hCAFE0010));
        vecs.push_back(mk(0, 0,            0, 0, 0, 0, 32'hFFFFFFFF, 3'd4, 5'b10100, 32'hFFFFFFFF, 0, 32'hFFFFFFFF));
        vecs.push_back(mk(0, 0,            0, 0, 0, 0, 0,            3'd0, 5'b00000, 32'hFFFFFFFF, 0, 32'hFFFFFFFF));

        foreach (vecs[i]) begin
            f_req = vecs[i].f_req; f_addr = vecs[i].f_addr;
            d_req = vecs[i].d_req; d_we = vecs[i].d_we; d_addr = vecs[i].d_addr;
            d_wdata = vecs[i].d_wdata; mem_rdata = vecs[i].mem_rdata;
            tick();
            chk($sformatf("vec%0d", i), observed(),
                {vecs[i].e_state, vecs[i].e_flags, vecs[i].e_addr, vecs[i].e_wdata, vecs[i].e_rdata});
        end

        // tie, both held until own done: data first, then fetch
        do_reset();
        f_req = 1; d_req = 1; f_addr = 32'h80; d_addr = 32'h200;
        dd_cyc = -1; fd_cyc = -1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            chk("gnt_excl", {103'd0, f_gnt & d_gnt}, 104'd0);
            if (d_done) dd_cyc = c;
            if (f_done) fd_cyc = c;
            if (dd_cyc != -1 && c == dd_cyc + 1) d_req = 0;
            if (fd_cyc != -1 && c == fd_cyc + 1) f_req = 0;
        end
        chk("tie_d_done_cycle", 104'(dd_cyc), 104'd4);
        chk("tie_f_done_cycle", 104'(fd_cyc), 104'd9);

        // both requests held continuously: grant order depends on tie policy
        do_reset();
        f_req = 1; d_req = 1;
`ifdef MEM_PORT_ARB_RR_EN
        exp_ord = '{1, 0, 1, 0};
`else
        exp_ord = '{1, 1, 1, 1};
`endif
        n = 0;
        for (int i = 0; i < 4; i++) got[i] = 1'b0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            tick();
            if (state_out == 3'd1) begin
                got[n] = d_gnt;
                n++;
            end
        end
        chk("cont_grant_count", 104'(n), 104'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("cont_grant%0d_is_data", i), 104'(got[i]), 104'(exp_ord[i]));

        // reset mid-ACCESS of a write drops mem_wr without a clock edge
        do_reset();
        d_req = 1; d_we = 1; d_addr = 32'h300; d_wdata = 32'hABCD;
        tick();
        chk("wr_access_mem_wr", 104'(mem_wr), 104'd1);
        #3 reset = 1;
        #1 chk("async_reset_access", observed(), 104'd0);
        reset = 0;
        idle_inputs();

        // reset pulse during WAIT1 of a data write abandons it
        tick();
        d_req = 1; d_we = 1; d_addr = 32'h300; d_wdata = 32'hABCD;
        tick();
        idle_inputs();
        tick();
        chk("pre_reset_wait1", 104'(state_out), 104'd2);
        #2 reset = 1;
        #1 chk("async_reset_wait1", observed(), 104'd0);
        #1 reset = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("no_done_after_reset", {101'd0, state_out, 1'b0} | {102'd0, f_done, d_done}, 104'd0);
        end

        f_req = 1; f_addr = 32'h44; mem_rdata = 32'h0BADF00D;
        lat = -1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (f_done && lat == -1) begin
                lat = c;
                chk("post_reset_rdata", 104'(rdata), 104'h0BADF00D);
            end
            if (lat != -1 && c == lat + 1) f_req = 0;
        end
        chk("post_reset_latency", 104'(lat), 104'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
